// File: rtl/rattlesnake_mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: datapath widths, one-hot
// state indices and the latched data-side request payload.
package rattlesnake_mem_port_arbiter_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned PC_BITWIDTH   = 32;
    localparam int unsigned MEM_ADDR_BITS = 16;

    // One-hot state bit positions
    localparam int unsigned S_IDLE  = 0;
    localparam int unsigned S_FETCH = 1;
    localparam int unsigned S_DATA  = 2;

    typedef enum logic [2:0] {
        StIdle  = 3'b001 << S_IDLE,
        StFetch = 3'b001 << S_FETCH,
        StData  = 3'b001 << S_DATA
    } arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [PC_BITWIDTH-1:0] addr;
        logic [XLEN-1:0]        wdata;
        logic [XLEN/8-1:0]      byte_en;
    } data_req_t;

endpackage

// File: rtl/rattlesnake_req_latch.sv
// Pending-request latch for one requester of the memory port.
// Ports:
//   clk, sync_reset  clock and synchronous active-high reset
//   set              request pulse; captures payload_in (last request wins)
//   clear            request granted this cycle; drops the pending flag
//   flush            drops an older pending request (a same-cycle set survives)
//   payload_in       request payload presented with set
//   pending          request available this cycle (includes a same-cycle set)
//   payload          payload of the available request (bypasses a same-cycle set)
module rattlesnake_req_latch
    import rattlesnake_mem_port_arbiter_pkg::*;
#(
    parameter int unsigned PayloadW = 32
) (
    input  logic                clk,
    input  logic                sync_reset,
    input  logic                set,
    input  logic                clear,
    input  logic                flush,
    input  logic [PayloadW-1:0] payload_in,
    output logic                pending,
    output logic [PayloadW-1:0] payload
);

    logic                pending_q, pending_d;
    logic [PayloadW-1:0] payload_q, payload_d;

    // The bypass lets the arbiter grant in the same cycle as the pulse.
    assign pending = set | (pending_q & ~flush);
    assign payload = set ? payload_in : payload_q;

    always_comb begin
        pending_d = pending_q;
        payload_d = payload_q;
        if (set) begin
            payload_d = payload_in;
        end
        // A grant consumes exactly the request visible on pending/payload, which
        // already includes any same-cycle set, so clear takes priority.
        if (clear) begin
            pending_d = 1'b0;
        end else if (set) begin
            pending_d = 1'b1;
        end else if (flush) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pending_q <= 1'b0;
            payload_q <= '0;
        end else begin
            pending_q <= pending_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: rtl/rattlesnake_mem_port_arbiter.sv
// Shares the single memory port between instruction fetch (read-only) and the
// load/store unit. Data requests win ties; one transaction outstanding at most.
// Ports:
//   clk, sync_reset                      clock, synchronous active-high reset
//   fetch_req/addr/flush                 fetch request pulse, byte address, flush
//   fetch_done/data/addr_ack             fetch response (halfword address echoed)
//   data_req/we/addr/wdata/byte_en       load/store request pulse and payload
//   data_done/rdata                      load/store completion, load data
//   mem_enable/we/addr/wdata/byte_en     one-cycle strobe and held request to memory
//   mem_done/rdata                       memory completion and read data
//   timeout_err                          pulse when the watchdog aborts a transaction
module rattlesnake_mem_port_arbiter
    import rattlesnake_mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    input  logic                     fetch_req,
    input  logic [PC_BITWIDTH-1:0]   fetch_addr,
    input  logic                     fetch_flush,
    output logic                     fetch_done,
    output logic [XLEN-1:0]          fetch_data,
    output logic [MEM_ADDR_BITS-1:0] fetch_addr_ack,
    input  logic                     data_req,
    input  logic                     data_we,
    input  logic [PC_BITWIDTH-1:0]   data_addr,
    input  logic [XLEN-1:0]          data_wdata,
    input  logic [XLEN/8-1:0]        data_byte_en,
    output logic                     data_done,
    output logic [XLEN-1:0]          data_rdata,
    output logic                     mem_enable,
    output logic                     mem_we,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [XLEN/8-1:0]        mem_byte_en,
    input  logic                     mem_done,
    input  logic [XLEN-1:0]          mem_rdata,
    output logic                     timeout_err
);

    localparam bit          WdogEn   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned WdogLast = WdogEn ? TIMEOUT_CYCLES - 1 : 0;
    localparam int unsigned WdogW    = $clog2(TIMEOUT_CYCLES + 1) + 1;

    arb_state_e state_q, state_d;

    logic                     fetch_pending, data_pending;
    logic [PC_BITWIDTH-1:0]   fetch_addr_l;
    data_req_t                data_in, data_l;
    logic                     fetch_grant, data_grant;

    logic                     mem_enable_q, mem_enable_d;
    logic                     mem_we_q, mem_we_d;
    logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]          mem_wdata_q, mem_wdata_d;
    logic [XLEN/8-1:0]        mem_byte_en_q, mem_byte_en_d;
    logic                     fetch_done_q, fetch_done_d;
    logic [XLEN-1:0]          fetch_data_q, fetch_data_d;
    logic [MEM_ADDR_BITS-1:0] fetch_addr_ack_q, fetch_addr_ack_d;
    logic                     data_done_q, data_done_d;
    logic [XLEN-1:0]          data_rdata_q, data_rdata_d;
    logic                     timeout_err_q, timeout_err_d;
    logic                     discard_q, discard_d;
    logic [WdogW-1:0]         wdog_q, wdog_d;
    logic                     wdog_expire;

    // Only the halfword address bits reach memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr_l[PC_BITWIDTH-1:MEM_ADDR_BITS+1], fetch_addr_l[0],
                                data_l.addr[PC_BITWIDTH-1:MEM_ADDR_BITS+1], data_l.addr[0]};

    assign data_in = '{we: data_we, addr: data_addr, wdata: data_wdata, byte_en: data_byte_en};

    rattlesnake_req_latch #(
        .PayloadW (PC_BITWIDTH)
    ) u_fetch_latch (
        .clk        (clk),
        .sync_reset (sync_reset),
        .set        (fetch_req),
        .clear      (fetch_grant),
        .flush      (fetch_flush),
        .payload_in (fetch_addr),
        .pending    (fetch_pending),
        .payload    (fetch_addr_l)
    );

    rattlesnake_req_latch #(
        .PayloadW ($bits(data_req_t))
    ) u_data_latch (
        .clk        (clk),
        .sync_reset (sync_reset),
        .set        (data_req),
        .clear      (data_grant),
        .flush      (1'b0),
        .payload_in (data_in),
        .pending    (data_pending),
        .payload    (data_l)
    );

    // The last wait cycle without mem_done aborts the transaction.
    assign wdog_expire = WdogEn && (wdog_q == WdogW'(WdogLast));

    always_comb begin
        state_d          = state_q;
        fetch_grant      = 1'b0;
        data_grant       = 1'b0;
        mem_enable_d     = 1'b0;
        mem_we_d         = mem_we_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        mem_byte_en_d    = mem_byte_en_q;
        fetch_done_d     = 1'b0;
        fetch_data_d     = fetch_data_q;
        fetch_addr_ack_d = fetch_addr_ack_q;
        data_done_d      = 1'b0;
        data_rdata_d     = data_rdata_q;
        timeout_err_d    = 1'b0;
        discard_d        = discard_q;
        wdog_d           = wdog_q;

        unique case (state_q)
            StIdle: begin
                if (data_pending) begin
                    data_grant    = 1'b1;
                    state_d       = StData;
                    mem_enable_d  = 1'b1;
                    mem_we_d      = data_l.we;
                    mem_addr_d    = data_l.addr[MEM_ADDR_BITS:1];
                    mem_wdata_d   = data_l.wdata;
                    mem_byte_en_d = data_l.byte_en;
                    wdog_d        = '0;
                    discard_d     = 1'b0;
                end else if (fetch_pending) begin
                    fetch_grant   = 1'b1;
                    state_d       = StFetch;
                    mem_enable_d  = 1'b1;
                    mem_we_d      = 1'b0;
                    mem_addr_d    = fetch_addr_l[MEM_ADDR_BITS:1];
                    mem_wdata_d   = '0;
                    mem_byte_en_d = '0;
                    wdog_d        = '0;
                    discard_d     = 1'b0;
                end
            end
            StFetch: begin
                if (mem_done) begin
                    state_d   = StIdle;
                    discard_d = 1'b0;
                    // A flush in the completing cycle also suppresses the response.
                    if (!(discard_q || fetch_flush)) begin
                        fetch_done_d     = 1'b1;
                        fetch_data_d     = mem_rdata;
                        fetch_addr_ack_d = mem_addr_q;
                    end
                end else if (wdog_expire) begin
                    state_d       = StIdle;
                    timeout_err_d = 1'b1;
                    discard_d     = 1'b0;
                end else begin
                    if (WdogEn) wdog_d = wdog_q + WdogW'(1);
                    if (fetch_flush) discard_d = 1'b1;
                end
            end
            StData: begin
                if (mem_done) begin
                    state_d      = StIdle;
                    data_done_d  = 1'b1;
                    data_rdata_d = mem_we_q ? '0 : mem_rdata;
                end else if (wdog_expire) begin
                    state_d       = StIdle;
                    timeout_err_d = 1'b1;
                end else if (WdogEn) begin
                    wdog_d = wdog_q + WdogW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q          <= StIdle;
            mem_enable_q     <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_byte_en_q    <= '0;
            fetch_done_q     <= 1'b0;
            fetch_data_q     <= '0;
            fetch_addr_ack_q <= '0;
            data_done_q      <= 1'b0;
            data_rdata_q     <= '0;
            timeout_err_q    <= 1'b0;
            discard_q        <= 1'b0;
            wdog_q           <= '0;
        end else begin
            state_q          <= state_d;
            mem_enable_q     <= mem_enable_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_byte_en_q    <= mem_byte_en_d;
            fetch_done_q     <= fetch_done_d;
            fetch_data_q     <= fetch_data_d;
            fetch_addr_ack_q <= fetch_addr_ack_d;
            data_done_q      <= data_done_d;
            data_rdata_q     <= data_rdata_d;
            timeout_err_q    <= timeout_err_d;
            discard_q        <= discard_d;
            wdog_q           <= wdog_d;
        end
    end

    assign mem_enable     = mem_enable_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_byte_en    = mem_byte_en_q;
    assign fetch_done     = fetch_done_q;
    assign fetch_data     = fetch_data_q;
    assign fetch_addr_ack = fetch_addr_ack_q;
    assign data_done      = data_done_q;
    assign data_rdata     = data_rdata_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_rattlesnake_mem_port_arbiter.sv
module tb_rattlesnake_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_flush;
    logic        fetch_done;
    logic [31:0] fetch_data;
    logic [15:0] fetch_addr_ack;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_byte_en;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        mem_enable;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int en_count     = 0;

    always #5 clk = ~clk;

    rattlesnake_mem_port_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .sync_reset     (sync_reset),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_flush    (fetch_flush),
        .fetch_done     (fetch_done),
        .fetch_data     (fetch_data),
        .fetch_addr_ack (fetch_addr_ack),
        .data_req       (data_req),
        .data_we        (data_we),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_byte_en   (data_byte_en),
        .data_done      (data_done),
        .data_rdata     (data_rdata),
        .mem_enable     (mem_enable),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_byte_en    (mem_byte_en),
        .mem_done       (mem_done),
        .mem_rdata      (mem_rdata),
        .timeout_err    (timeout_err)
    );

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_enable) en_count++;
    endtask

    task automatic test_reset();
        sync_reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({mem_enable, mem_we, timeout_err, fetch_done, data_done} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {mem_enable, mem_we, timeout_err, fetch_done, data_done});
        end
        tests_run++;
        if ({mem_addr, mem_wdata, mem_byte_en} !== 52'h0) begin
            tests_failed++;
            $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata, mem_byte_en});
        end
        tests_run++;
        if ({fetch_data, fetch_addr_ack, data_rdata} !== 80'h0) begin
            tests_failed++;
            $display("FAIL reset_resp: got %h want 0", {fetch_data, fetch_addr_ack, data_rdata});
        end
        sync_reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        fetch_addr = 32'h100;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
        tests_run++;
        if ({mem_enable, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0080}) begin
            tests_failed++;
            $display("FAIL fetch_grant: got en=%b we=%b addr=%h want en=1 we=0 addr=0080",
                     mem_enable, mem_we, mem_addr);
        end
        tick();
        tests_run++;
        if ({mem_enable, mem_addr} !== {1'b0, 16'h0080}) begin
            tests_failed++;
            $display("FAIL fetch_hold: got en=%b addr=%h want en=0 addr=0080",
                     mem_enable, mem_addr);
        end
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_0013;
        tick();
        mem_done  = 1'b0;
        mem_rdata = 32'h0;
        tests_run++;
        if ({fetch_done, data_done, fetch_data, fetch_addr_ack} !==
            {1'b1, 1'b0, 32'h0000_0013, 16'h0080}) begin
            tests_failed++;
            $display("FAIL fetch_resp: got done=%b ddone=%b data=%h ack=%h want 1 0 00000013 0080",
                     fetch_done, data_done, fetch_data, fetch_addr_ack);
        end
        tick();
        tests_run++;
        if (fetch_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_done_pulse: got %b want 0", fetch_done);
        end
    endtask

    task automatic test_back_to_back();
        en_count   = 0;
        fetch_addr = 32'h200;
        fetch_req  = 1'b1;
        data_addr  = 32'h1000;
        data_we    = 1'b0;
        data_req   = 1'b1;
        tick();
        fetch_req = 1'b0;
        data_req  = 1'b0;
        tests_run++;
        if ({mem_enable, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0800}) begin
            tests_failed++;
            $display("FAIL prio_data_first: got en=%b we=%b addr=%h want 1 0 0800",
                     mem_enable, mem_we, mem_addr);
        end
        tick();
        mem_done  = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_done = 1'b0;
        tests_run++;
        if ({data_done, fetch_done, data_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            tests_failed++;
            $display("FAIL prio_data_resp: got dd=%b fd=%b rdata=%h want 1 0 cafef00d",
                     data_done, fetch_done, data_rdata);
        end
        tick();
        tests_run++;
        if ({mem_enable, mem_addr} !== {1'b1, 16'h0100}) begin
            tests_failed++;
            $display("FAIL prio_fetch_next: got en=%b addr=%h want 1 0100", mem_enable, mem_addr);
        end
        mem_done  = 1'b1;
        mem_rdata = 32'h0010_0093;
        tick();
        mem_done = 1'b0;
        tests_run++;
        if ({fetch_done, fetch_data, fetch_addr_ack} !== {1'b1, 32'h0010_0093, 16'h0100}) begin
            tests_failed++;
            $display("FAIL prio_fetch_resp: got fd=%b data=%h ack=%h want 1 00100093 0100",
                     fetch_done, fetch_data, fetch_addr_ack);
        end
        tick();
        tick();
        tests_run++;
        if (en_count !== 2) begin
            tests_failed++;
            $display("FAIL prio_pulse_count: got %0d want 2", en_count);
        end
    endtask

    task automatic test_flush();
        fetch_addr = 32'h100;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
        tests_run++;
        if (mem_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_grant: got %b want 1", mem_enable);
        end
        fetch_flush = 1'b1;
        tick();
        fetch_flush = 1'b0;
        mem_done    = 1'b1;
        mem_rdata   = 32'h0000_0BAD;
        tick();
        mem_done = 1'b0;
        tests_run++;
        if (fetch_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_discard: got fetch_done=%b want 0", fetch_done);
        end
        tick();
        tests_run++;
        if ({fetch_done, mem_enable} !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_idle: got fd/en=%b want 00", {fetch_done, mem_enable});
        end
        fetch_addr = 32'h300;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
        tests_run++;
        if ({mem_enable, mem_addr} !== {1'b1, 16'h0180}) begin
            tests_failed++;
            $display("FAIL flush_refetch_grant: got en=%b addr=%h want 1 0180", mem_enable, mem_addr);
        end
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_0013;
        tick();
        mem_done = 1'b0;
        tests_run++;
        if ({fetch_done, fetch_data, fetch_addr_ack} !== {1'b1, 32'h0000_0013, 16'h0180}) begin
            tests_failed++;
            $display("FAIL flush_refetch_resp: got fd=%b data=%h ack=%h want 1 00000013 0180",
                     fetch_done, fetch_data, fetch_addr_ack);
        end
        // A request arriving together with a flush is the new target and survives.
        fetch_addr  = 32'h40;
        fetch_req   = 1'b1;
        fetch_flush = 1'b1;
        tick();
        fetch_req   = 1'b0;
        fetch_flush = 1'b0;
        tests_run++;
        if ({mem_enable, mem_addr} !== {1'b1, 16'h0020}) begin
            tests_failed++;
            $display("FAIL flush_same_cycle_req: got en=%b addr=%h want 1 0020", mem_enable, mem_addr);
        end
        mem_done  = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_done = 1'b0;
        tests_run++;
        if ({fetch_done, fetch_data} !== {1'b1, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL flush_same_cycle_resp: got fd=%b data=%h want 1 12345678",
                     fetch_done, fetch_data);
        end
        tick();
    endtask

    task automatic test_store();
        data_we      = 1'b1;
        data_addr    = 32'h4;
        data_wdata   = 32'hDEAD_BEEF;
        data_byte_en = 4'b0011;
        data_req     = 1'b1;
        tick();
        data_req = 1'b0;
        data_we  = 1'b0;
        tests_run++;
        if ({mem_enable, mem_we, mem_addr, mem_wdata, mem_byte_en} !==
            {1'b1, 1'b1, 16'h0002, 32'hDEAD_BEEF, 4'b0011}) begin
            tests_failed++;
            $display("FAIL store_bus: got en=%b we=%b addr=%h wd=%h be=%b want 1 1 0002 deadbeef 0011",
                     mem_enable, mem_we, mem_addr, mem_wdata, mem_byte_en);
        end
        tick();
        mem_done  = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        mem_done = 1'b0;
        tests_run++;
        if ({data_done, fetch_done, data_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL store_done: got dd=%b fd=%b rdata=%h want 1 0 00000000",
                     data_done, fetch_done, data_rdata);
        end
        tick();
    endtask

    task automatic test_watchdog();
        data_we   = 1'b0;
        data_addr = 32'h10;
        data_req  = 1'b1;
        tick();                     // wait cycle 1
        data_req = 1'b0;
        tests_run++;
        if ({mem_enable, mem_addr} !== {1'b1, 16'h0008}) begin
            tests_failed++;
            $display("FAIL wdog_grant: got en=%b addr=%h want 1 0008", mem_enable, mem_addr);
        end
        tick();                     // wait cycle 2
        data_addr = 32'h20;
        data_req  = 1'b1;
        tick();                     // wait cycle 3
        data_req = 1'b0;
        for (int i = 4; i <= 8; i++) begin
            tick();
            tests_run++;
            if (timeout_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL wdog_early_%0d: got %b want 0", i, timeout_err);
            end
        end
        tick();
        tests_run++;
        if ({timeout_err, data_done, mem_enable} !== 3'b100) begin
            tests_failed++;
            $display("FAIL wdog_abort: got err/dd/en=%b want 100",
                     {timeout_err, data_done, mem_enable});
        end
        tick();                     // pending request granted after abort
        tests_run++;
        if ({mem_enable, mem_addr, timeout_err} !== {1'b1, 16'h0010, 1'b0}) begin
            tests_failed++;
            $display("FAIL wdog_regrant: got en=%b addr=%h err=%b want 1 0010 0",
                     mem_enable, mem_addr, timeout_err);
        end
        for (int i = 0; i < 7; i++) tick();   // reach wait cycle 8
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_0077;
        tick();
        mem_done = 1'b0;
        tests_run++;
        if ({data_done, timeout_err, data_rdata} !== {1'b1, 1'b0, 32'h0000_0077}) begin
            tests_failed++;
            $display("FAIL wdog_done_wins: got dd=%b err=%b rdata=%h want 1 0 00000077",
                     data_done, timeout_err, data_rdata);
        end
        tick();
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wdog_no_late_err: got %b want 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        data_we   = 1'b0;
        data_addr = 32'h40;
        data_req  = 1'b1;
        tick();
        data_req = 1'b0;
        tests_run++;
        if ({mem_enable, mem_addr} !== {1'b1, 16'h0020}) begin
            tests_failed++;
            $display("FAIL rst_mid_grant: got en=%b addr=%h want 1 0020", mem_enable, mem_addr);
        end
        tick();
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        tests_run++;
        if ({mem_enable, mem_addr, data_done} !== {1'b0, 16'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_mid_clear: got en=%b addr=%h dd=%b want 0 0000 0",
                     mem_enable, mem_addr, data_done);
        end
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_0099;
        tick();
        mem_done = 1'b0;
        tests_run++;
        if ({data_done, fetch_done, mem_enable, data_rdata} !== {3'b000, 32'h0}) begin
            tests_failed++;
            $display("FAIL rst_late_done: got dd=%b fd=%b en=%b rdata=%h want 0 0 0 00000000",
                     data_done, fetch_done, mem_enable, data_rdata);
        end
        tick();
    endtask

    initial begin
        sync_reset   = 1'b1;
        fetch_req    = 1'b0;
        fetch_addr   = '0;
        fetch_flush  = 1'b0;
        data_req     = 1'b0;
        data_we      = 1'b0;
        data_addr    = '0;
        data_wdata   = '0;
        data_byte_en = '0;
        mem_done     = 1'b0;
        mem_rdata    = '0;

        test_reset();
        test_fetch();
        test_back_to_back();
        test_flush();
        test_store();
        test_watchdog();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
